// File: rtl/sysid_poll_pkg.sv
// Shared types and constants for the sysid poll controller and its arbiter.
package sysid_poll_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      RD_TS,
      CMP,
      DONE
   } state_t;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;
   localparam int   LAT_W   = 3;

endpackage

// File: rtl/sysid_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past the last winner on each done strobe.
module sysid_rr_arb2 (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       take,
   input  logic       update,
   output logic [1:0] win
);

   logic prio;
   logic last;

   // A lone request always wins; on a tie the pointer picks the side not served last.
   always_comb begin
      win = req;
      if (req == 2'b11) begin
         win = prio ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prio <= 1'b0;
         last <= 1'b0;
      end else begin
         if (take) begin
            last <= win[1];
         end
         if (update) begin
            prio <= ~last;
         end
      end
   end

endmodule

// File: rtl/sysid_poll_ctrl.sv
// Arbitrated two-word read sequencer for the sysid slave with build-value compare.
// Optional periodic auto-poll and sticky mismatch flag: define SYSID_POLL_PERIODIC_EN.
module sysid_poll_ctrl
   import sysid_poll_pkg::*;
#(
   parameter logic [31:0] EXP_ID      = 32'h0000_0000,
   parameter logic [31:0] EXP_TS      = 32'd1461104899,
   parameter int          READ_LAT    = 1,
   parameter int          POLL_PERIOD = 1000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  req,
   output logic [1:0]  gnt,
   output logic        busy,
   output logic        done,
   output logic        match,
   output logic [31:0] id_out,
   output logic [31:0] ts_out,
   output logic        mismatch_sticky,
   output logic        sysid_address,
   input  logic [31:0] sysid_readdata
);

   generate
      if (READ_LAT < 1 || READ_LAT > 7) begin : g_bad_lat
         $error("sysid_poll_ctrl: READ_LAT must be in 1..7");
      end
      if (POLL_PERIOD < 1) begin : g_bad_period
         $error("sysid_poll_ctrl: POLL_PERIOD must be at least 1");
      end
   endgenerate

   localparam logic [LAT_W-1:0] LAST_CNT = LAT_W'(READ_LAT - 1);

   state_t           state;
   state_t           state_nxt;
   logic [LAT_W-1:0] cnt;
   logic             lat_last;
   logic [1:0]       win;
   logic             take;
   logic             auto_run;
   logic             poll_go;

   assign lat_last = (cnt == LAST_CNT);

   sysid_rr_arb2 u_arb (
      .clock  (clock),
      .reset  (reset),
      .req    (req),
      .take   (take),
      .update ((state == DONE) && !auto_run),
      .win    (win)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Requesters outrank a pending auto-poll; req is only looked at in IDLE.
   always_comb begin
      state_nxt     = state;
      take          = 1'b0;
      busy          = (state != IDLE);
      done          = (state == DONE);
      sysid_address = (state == RD_TS) ? ADDR_TS : ADDR_ID;
      case (state)
         IDLE: begin
            if (req != 2'b00) begin
               take      = 1'b1;
               state_nxt = RD_ID;
            end else if (poll_go) begin
               state_nxt = RD_ID;
            end
         end
         RD_ID:   if (lat_last) state_nxt = RD_TS;
         RD_TS:   if (lat_last) state_nxt = CMP;
         CMP:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt      <= '0;
         gnt      <= 2'b00;
         auto_run <= 1'b0;
         id_out   <= '0;
         ts_out   <= '0;
         match    <= 1'b0;
      end else begin
         if ((state == RD_ID || state == RD_TS) && !lat_last) begin
            cnt <= cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
         if (state == IDLE && state_nxt == RD_ID) begin
            gnt      <= take ? win : 2'b00;
            auto_run <= !take;
         end else if (state == CMP) begin
            gnt <= 2'b00;
         end
         if (state == RD_ID && lat_last) begin
            id_out <= sysid_readdata;
         end
         if (state == RD_TS && lat_last) begin
            ts_out <= sysid_readdata;
         end
         if (state == CMP) begin
            match <= (id_out == EXP_ID) && (ts_out == EXP_TS);
         end
      end
   end

`ifdef SYSID_POLL_PERIODIC_EN
   logic [31:0] poll_cnt;
   logic        poll_pend;
   logic        sticky;

   // The pending flag is consumed only when IDLE actually launches the auto-poll.
   always_ff @(posedge clock) begin
      if (reset) begin
         poll_cnt  <= 32'(POLL_PERIOD - 1);
         poll_pend <= 1'b0;
         sticky    <= 1'b0;
      end else begin
         if (state == IDLE && req == 2'b00 && poll_pend) begin
            poll_pend <= 1'b0;
         end
         if (poll_cnt == 32'd0) begin
            poll_cnt  <= 32'(POLL_PERIOD - 1);
            poll_pend <= 1'b1;
         end else begin
            poll_cnt <= poll_cnt - 32'd1;
         end
         if (state == DONE && !match) begin
            sticky <= 1'b1;
         end
      end
   end

   assign poll_go         = poll_pend;
   assign mismatch_sticky = sticky;
`else
   assign poll_go         = 1'b0;
   assign mismatch_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_sysid_poll_ctrl.sv
// Directed bench for sysid_poll_ctrl: READ_LAT=1 instance plus a READ_LAT=3 instance.
module tb_sysid_poll_ctrl;

   localparam logic [31:0] TS_GOOD = 32'd1461104899;
   localparam logic [31:0] TS_BAD  = 32'd1461104900;
`ifdef SYSID_POLL_PERIODIC_EN
   localparam logic STICKY_AFTER_MISS = 1'b1;
`else
   localparam logic STICKY_AFTER_MISS = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  req;
   logic [1:0]  gnt;
   logic        busy, done, match, mismatch_sticky, sysid_address;
   logic [31:0] id_out, ts_out, sysid_readdata;
   logic [31:0] ts_val;

   logic [1:0]  req3;
   logic [1:0]  gnt3;
   logic        busy3, done3, match3, sticky3, addr3;
   logic [31:0] id3, ts3, rdata3;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   // Combinational sysid slave models: address 0 gives the ID, address 1 the timestamp.
   assign sysid_readdata = sysid_address ? ts_val : 32'h0000_0000;
   assign rdata3         = addr3 ? TS_GOOD : 32'h0000_0000;

   sysid_poll_ctrl #(.READ_LAT(1)) dut (
      .clock           (clock),
      .reset           (reset),
      .req             (req),
      .gnt             (gnt),
      .busy            (busy),
      .done            (done),
      .match           (match),
      .id_out          (id_out),
      .ts_out          (ts_out),
      .mismatch_sticky (mismatch_sticky),
      .sysid_address   (sysid_address),
      .sysid_readdata  (sysid_readdata)
   );

   sysid_poll_ctrl #(.READ_LAT(3)) dut3 (
      .clock           (clock),
      .reset           (reset),
      .req             (req3),
      .gnt             (gnt3),
      .busy            (busy3),
      .done            (done3),
      .match           (match3),
      .id_out          (id3),
      .ts_out          (ts3),
      .mismatch_sticky (sticky3),
      .sysid_address   (addr3),
      .sysid_readdata  (rdata3)
   );

   task automatic applyStimulus(input logic [1:0] r, input int cycles);
      req = r;
      repeat (cycles) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset  = 1'b1;
      req    = 2'b00;
      req3   = 2'b00;
      ts_val = TS_GOOD;
      @(negedge clock);
      applyStimulus(2'b00, 2);
      checkOutput("rst_gnt", 32'(gnt), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_done", 32'(done), 32'h0);
      checkOutput("rst_ts", ts_out, 32'h0);
      checkOutput("rst_addr", 32'(sysid_address), 32'h0);
      reset = 1'b0;

      // Single request; req drops right after the grant.
      applyStimulus(2'b01, 1);
      checkOutput("t1_gnt", 32'(gnt), 32'h1);
      checkOutput("t1_busy", 32'(busy), 32'h1);
      checkOutput("t1_addr_id", 32'(sysid_address), 32'h0);
      applyStimulus(2'b00, 1);
      checkOutput("t1_addr_ts", 32'(sysid_address), 32'h1);
      applyStimulus(2'b00, 1);
      checkOutput("t1_cmp_done", 32'(done), 32'h0);
      applyStimulus(2'b00, 1);
      checkOutput("t1_done", 32'(done), 32'h1);
      checkOutput("t1_done_gnt", 32'(gnt), 32'h0);
      checkOutput("t1_match", 32'(match), 32'h1);
      checkOutput("t1_id", id_out, 32'h0);
      checkOutput("t1_ts", ts_out, TS_GOOD);
      applyStimulus(2'b00, 1);
      checkOutput("t1_done_pulse", 32'(done), 32'h0);
      checkOutput("t1_idle_busy", 32'(busy), 32'h0);
      checkOutput("t1_match_hold", 32'(match), 32'h1);

      // Fresh pointer, both requesting continuously: 01, 10, 01.
      reset = 1'b1;
      applyStimulus(2'b00, 1);
      reset = 1'b0;
      applyStimulus(2'b11, 1);
      checkOutput("t2_gnt_a", 32'(gnt), 32'h1);
      applyStimulus(2'b11, 3);
      checkOutput("t2_done_a", 32'(done), 32'h1);
      checkOutput("t2_gap_a", 32'(gnt), 32'h0);
      applyStimulus(2'b11, 1);
      checkOutput("t2_idle_a", 32'(busy), 32'h0);
      checkOutput("t2_idle_gnt", 32'(gnt), 32'h0);
      applyStimulus(2'b11, 1);
      checkOutput("t2_gnt_b", 32'(gnt), 32'h2);
      applyStimulus(2'b11, 3);
      checkOutput("t2_done_b", 32'(done), 32'h1);
      applyStimulus(2'b11, 1);
      checkOutput("t2_idle_b", 32'(busy), 32'h0);
      applyStimulus(2'b11, 1);
      checkOutput("t2_gnt_c", 32'(gnt), 32'h1);
      applyStimulus(2'b00, 3);
      checkOutput("t2_done_c", 32'(done), 32'h1);
      applyStimulus(2'b00, 1);

      // Wrong timestamp, then a passing check from the other requester.
      ts_val = TS_BAD;
      applyStimulus(2'b01, 1);
      checkOutput("t3_gnt", 32'(gnt), 32'h1);
      applyStimulus(2'b00, 3);
      checkOutput("t3_done", 32'(done), 32'h1);
      checkOutput("t3_match", 32'(match), 32'h0);
      checkOutput("t3_id", id_out, 32'h0);
      checkOutput("t3_ts", ts_out, TS_BAD);
      applyStimulus(2'b00, 1);
      checkOutput("t3_sticky", 32'(mismatch_sticky), 32'(STICKY_AFTER_MISS));
      ts_val = TS_GOOD;
      applyStimulus(2'b10, 1);
      checkOutput("t3_gnt_b", 32'(gnt), 32'h2);
      applyStimulus(2'b00, 3);
      checkOutput("t3_match_b", 32'(match), 32'h1);
      checkOutput("t3_sticky_b", 32'(mismatch_sticky), 32'(STICKY_AFTER_MISS));
      applyStimulus(2'b00, 1);

      // Reset while in RD_TS, then a normal transaction.
      applyStimulus(2'b01, 2);
      checkOutput("t5_in_rdts", 32'(sysid_address), 32'h1);
      reset = 1'b1;
      applyStimulus(2'b00, 1);
      checkOutput("t5_gnt", 32'(gnt), 32'h0);
      checkOutput("t5_busy", 32'(busy), 32'h0);
      checkOutput("t5_done", 32'(done), 32'h0);
      checkOutput("t5_match", 32'(match), 32'h0);
      checkOutput("t5_ts", ts_out, 32'h0);
      checkOutput("t5_addr", 32'(sysid_address), 32'h0);
      reset = 1'b0;
      applyStimulus(2'b10, 1);
      checkOutput("t5_gnt_after", 32'(gnt), 32'h2);
      applyStimulus(2'b00, 3);
      checkOutput("t5_done_after", 32'(done), 32'h1);
      checkOutput("t5_match_after", 32'(match), 32'h1);
      checkOutput("t5_ts_after", ts_out, TS_GOOD);
      applyStimulus(2'b00, 1);

      // READ_LAT=3 instance: address low for 3 cycles, high for 3, done in cycle 8.
      req3 = 2'b01;
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(2'b00, 1);
         req3 = 2'b00;
         checkOutput($sformatf("t4_addr_c%0d", k), 32'(addr3),
                     (k >= 4 && k <= 6) ? 32'h1 : 32'h0);
         checkOutput($sformatf("t4_done_c%0d", k), 32'(done3),
                     (k == 8) ? 32'h1 : 32'h0);
      end
      checkOutput("t4_match", 32'(match3), 32'h1);
      checkOutput("t4_id", id3, 32'h0);
      checkOutput("t4_ts", ts3, TS_GOOD);
      checkOutput("t4_gnt_done", 32'(gnt3), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
